// File: rtl/mem_bist_master.sv
`default_nettype none
// ============================================================================
// Module  : mem_bist_master
// Brief   : Write/read-back self-test initiator for a valid/ready single-port
//           memory. Optional handshake watchdog under macro BIST_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module mem_bist_master #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int ERR_WIDTH  = $clog2(DEPTH + 1),
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [WIDTH-1:0]      seed_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [ERR_WIDTH-1:0]  err_count_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic                  timeout_o,
    output logic                  valid_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [WIDTH-1:0]      wdata_o,
    output logic                  wr_rd_o,
    input  logic                  ready_i,
    input  logic [WIDTH-1:0]      rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR_REQ = 3'd1,
        S_WR_GAP = 3'd2,
        S_RD_REQ = 3'd3,
        S_RD_GAP = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [WIDTH-1:0]      r_seed;
    logic [WIDTH-1:0]      w_expect;
    logic [ERR_WIDTH-1:0]  r_err;
    logic [ADDR_WIDTH-1:0] r_fail_addr;
    logic                  r_pass;
    logic                  w_last;
    logic                  w_timeout_hit;

    assign w_last      = (r_addr == c_LAST_ADDR);
    assign w_expect    = r_seed ^ WIDTH'(r_addr);
    assign addr_o      = r_addr;
    assign wdata_o     = w_expect;
    assign err_count_o = r_err;
    assign fail_addr_o = r_fail_addr;
    assign pass_o      = r_pass;

`ifdef BIST_TIMEOUT_EN
    localparam int c_WAIT_WIDTH = $clog2(TIMEOUT + 1);

    logic [c_WAIT_WIDTH-1:0] r_wait;
    logic                    w_exit;
    logic                    w_waiting;
    logic                    r_timeout;

    always_comb begin
        w_exit    = 1'b0;
        w_waiting = 1'b0;
        case (r_state)
            S_WR_REQ, S_RD_REQ: begin w_exit = ready_i;  w_waiting = !ready_i; end
            S_WR_GAP, S_RD_GAP: begin w_exit = !ready_i; w_waiting = ready_i;  end
            default: ;
        endcase
    end

    assign w_timeout_hit = w_waiting && (r_wait == c_WAIT_WIDTH'(TIMEOUT - 1));
    assign timeout_o     = r_timeout;

    // Any state change (including the entry from IDLE) restarts the wait count.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wait    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_next_state != r_state)
                r_wait <= '0;
            else if (w_waiting)
                r_wait <= r_wait + c_WAIT_WIDTH'(1);
            if (r_state == S_IDLE && start_i)
                r_timeout <= 1'b0;
            else if (w_timeout_hit)
                r_timeout <= 1'b1;
        end
    end
`else
    assign w_timeout_hit = 1'b0;
    assign timeout_o     = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        valid_o      = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        wr_rd_o      = 1'b0;
        case (r_state)
            S_IDLE: if (start_i) w_next_state = S_WR_REQ;
            S_WR_REQ: begin
                valid_o = 1'b1;
                busy_o  = 1'b1;
                wr_rd_o = 1'b1;
                if (ready_i) w_next_state = S_WR_GAP;
            end
            S_WR_GAP: begin
                busy_o  = 1'b1;
                wr_rd_o = 1'b1;
                if (!ready_i) w_next_state = w_last ? S_RD_REQ : S_WR_REQ;
            end
            S_RD_REQ: begin
                valid_o = 1'b1;
                busy_o  = 1'b1;
                if (ready_i) w_next_state = S_RD_GAP;
            end
            S_RD_GAP: begin
                busy_o = 1'b1;
                if (!ready_i) w_next_state = w_last ? S_DONE : S_RD_REQ;
            end
            S_DONE: begin
                done_o       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
        if (w_timeout_hit) w_next_state = S_DONE;
    end

    // A timeout never reaches the normal finish, so pass stays at its cleared 0.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_addr      <= '0;
            r_seed      <= '0;
            r_err       <= '0;
            r_fail_addr <= '0;
            r_pass      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_seed      <= seed_i;
                        r_addr      <= '0;
                        r_err       <= '0;
                        r_fail_addr <= '0;
                        r_pass      <= 1'b0;
                    end
                end
                S_RD_REQ: begin
                    if (ready_i && (rdata_i != w_expect)) begin
                        r_err <= r_err + ERR_WIDTH'(1);
                        if (r_err == '0) r_fail_addr <= r_addr;
                    end
                end
                S_WR_GAP: begin
                    if (!ready_i && !w_timeout_hit)
                        r_addr <= w_last ? '0 : r_addr + ADDR_WIDTH'(1);
                end
                S_RD_GAP: begin
                    if (!ready_i && !w_timeout_hit) begin
                        if (w_last)
                            r_pass <= (r_err == '0);
                        else
                            r_addr <= r_addr + ADDR_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bist_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_bist_master
// Brief   : Self-checking bench for mem_bist_master with a behavioural memory.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_bist_master;

    localparam int WIDTH = 16;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int EW    = 7;
    localparam int TMO   = 16;

    logic            clk_i = 1'b0;
    logic            reset_i = 1'b1;
    logic            start_i = 1'b0;
    logic [WIDTH-1:0] seed_i = '0;
    logic            busy_o, done_o, pass_o, timeout_o, valid_o, wr_rd_o;
    logic [EW-1:0]   err_count_o;
    logic [AW-1:0]   fail_addr_o, addr_o;
    logic [WIDTH-1:0] wdata_o;
    logic            ready_i;
    logic [WIDTH-1:0] rdata_i;

    int checks = 0;
    int errors = 0;

    mem_bist_master #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .ERR_WIDTH(EW), .TIMEOUT(TMO)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .seed_i(seed_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .err_count_o(err_count_o),
        .fail_addr_o(fail_addr_o), .timeout_o(timeout_o), .valid_o(valid_o),
        .addr_o(addr_o), .wdata_o(wdata_o), .wr_rd_o(wr_rd_o),
        .ready_i(ready_i), .rdata_i(rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural zero-wait memory: ready follows valid by one cycle.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] corrupt = '0;
    bit               stuck = 1'b0;

    always @(posedge clk_i) begin
        if (reset_i) begin
            ready_i <= 1'b0;
            rdata_i <= '0;
        end else begin
            ready_i <= valid_o && !stuck;
            if (valid_o && wr_rd_o) mem[addr_o] <= wdata_o;
            if (valid_o && !wr_rd_o) rdata_i <= mem[addr_o] ^ {15'd0, corrupt[addr_o]};
        end
    end

    // Protocol monitor and handshake log.
    logic [AW:0]      hs_log[$];
    int               viol = 0;
    logic             p_rst = 1'b1, p_valid = 1'b0, p_ready = 1'b0, p_wr = 1'b0;
    logic [AW-1:0]    p_addr = '0;
    logic [WIDTH-1:0] p_wdata = '0;

    always @(negedge clk_i) begin
        if (!reset_i && !p_rst) begin
            if (p_valid && !p_ready && !stuck &&
                !(valid_o && addr_o == p_addr && wdata_o == p_wdata && wr_rd_o == p_wr))
                viol++;
            if (!p_valid && valid_o && ready_i) viol++;
        end
        if (!reset_i && valid_o && ready_i) hs_log.push_back({wr_rd_o, addr_o});
        p_rst = reset_i; p_valid = valid_o; p_ready = ready_i;
        p_wr = wr_rd_o; p_addr = addr_o; p_wdata = wdata_o;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_test(input logic [WIDTH-1:0] seed);
        hs_log.delete();
        seed_i  = seed;
        start_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input bit pulse_mid, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < 2000) begin
            @(posedge clk_i);
            cyc++;
            @(negedge clk_i);
            if (done_o) begin ok = 1'b1; break; end
            start_i = pulse_mid && (cyc == 100);
        end
        start_i = 1'b0;
    endtask

    // Full run plus comparison against the reference outcome of the corruption set.
    task automatic run_and_check(input string tag, input logic [WIDTH-1:0] seed, input bit pulse_mid);
        int cyc, exp_err, exp_fail, bad_mem, bad_log;
        bit ok, found;
        exp_err = 0; exp_fail = 0; found = 1'b0;
        for (int a = 0; a < DEPTH; a++)
            if (corrupt[a]) begin
                exp_err++;
                if (!found) begin exp_fail = a; found = 1'b1; end
            end
        start_test(seed);
        wait_done(pulse_mid, cyc, ok);
        chk({tag, "_done_seen"}, ok, 1'b1);
        chk({tag, "_cycles"}, cyc, 8 * DEPTH);
        chk({tag, "_pass"}, pass_o, exp_err == 0);
        chk({tag, "_err"}, err_count_o, exp_err);
        chk({tag, "_fail_addr"}, fail_addr_o, exp_fail);
        chk({tag, "_timeout"}, timeout_o, 1'b0);
        bad_mem = 0;
        for (int a = 0; a < DEPTH; a++)
            if (mem[a] !== (seed ^ WIDTH'(a))) bad_mem++;
        chk({tag, "_mem_contents"}, bad_mem, 0);
        bad_log = (hs_log.size() == 2 * DEPTH) ? 0 : 1000;
        for (int k = 0; k < hs_log.size() && k < 2 * DEPTH; k++)
            if (hs_log[k] !== ((k < DEPTH) ? {1'b1, AW'(k)} : {1'b0, AW'(k - DEPTH)})) bad_log++;
        chk({tag, "_hs_order"}, bad_log, 0);
        @(negedge clk_i);
        chk({tag, "_done_pulse_1cyc"}, {done_o, busy_o, pass_o}, {2'b00, exp_err == 0});
    endtask

    initial begin
        int cyc;
        bit ok;
        logic [WIDTH-1:0] s;

        // Reset held 3 cycles with start asserted.
        reset_i = 1'b1;
        start_i = 1'b1;
        seed_i  = 16'h1234;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_outputs",
            {busy_o, done_o, pass_o, err_count_o, fail_addr_o, timeout_o, valid_o, addr_o, wdata_o, wr_rd_o},
            '0);
        reset_i = 1'b0;
        start_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("idle_after_rst", {busy_o, valid_o}, 2'b00);

        corrupt = '0;
        run_and_check("clean_a5a5", 16'hA5A5, 1'b0);

        corrupt = '0;
        corrupt[5] = 1'b1;
        corrupt[9] = 1'b1;
        run_and_check("flip_5_9", WIDTH'($urandom), 1'b0);

        for (int t = 0; t < 3; t++) begin
            corrupt = '0;
            for (int a = 0; a < DEPTH; a++)
                if ($urandom_range(0, 11) == 0) corrupt[a] = 1'b1;
            corrupt[DEPTH-1] = (t == 1);
            run_and_check($sformatf("rand%0d", t), WIDTH'($urandom), 1'b0);
        end

        // Reset in the middle of the write phase at address 10.
        corrupt = '0;
        start_test(16'h0F0F);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (valid_o && wr_rd_o && addr_o == AW'(10)) ok = 1'b1;
            else @(negedge clk_i);
        end
        chk("reach_addr10", ok, 1'b1);
        reset_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("midrst_valid_busy", {valid_o, busy_o}, 2'b00);
        reset_i = 1'b0;
        @(negedge clk_i);
        s = WIDTH'($urandom);
        corrupt = '0;
        corrupt[33] = 1'b1;
        run_and_check("restart_pulse", s, 1'b1);

        chk("protocol_violations", viol, 0);

        // Memory that never answers.
        stuck = 1'b1;
        start_test(16'h5A5A);
`ifdef BIST_TIMEOUT_EN
        wait_done(1'b0, cyc, ok);
        chk("tmo_done_seen", ok, 1'b1);
        chk("tmo_cycles", cyc, TMO);
        chk("tmo_flags", {timeout_o, pass_o, err_count_o}, {2'b10, EW'(0)});
        @(negedge clk_i);
        chk("tmo_after", {valid_o, busy_o, timeout_o}, 3'b001);
`else
        repeat (100) @(negedge clk_i);
        chk("stuck_busy_valid", {busy_o, valid_o, timeout_o, done_o}, 4'b1100);
`endif
        reset_i = 1'b1;
        stuck   = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        chk("final_rst", {busy_o, valid_o, timeout_o}, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
